ip4_rtl_spa_svseq: RTL and testbench
====================================

Name: ip4_rtl_spa_svseq

Overview:
Sub-vector issue sequencer in front of the stream processor array (SPA). It accepts one vector instruction at a time from the issue stage (ISE) and issues it to the SPA lanes as NUM_SP-wide sub-vectors, one per cycle. It skips sub-vectors whose element mask is all zero, honours SPA stall, and cancels the remaining sub-vectors of a thread when an execute exception is reported. Each instruction ends with a single done pulse.

Parameters:
NUM_SP, 8, lanes per sub-vector
MAX_SV, 4, max sub-vectors per instruction (power of 2)
TID_W, 3, thread id width
OP_W, 8, opcode width (passed through, not decoded)
SV_W, $clog2(MAX_SV), localparam, sub-vector index width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
in_vld  in  1  ISE instruction valid
in_rdy  out  1  sequencer accepts instruction
in_tid  in  TID_W  thread id
in_op  in  OP_W  opcode
in_nsv  in  SV_W  number of sub-vectors minus 1
in_emsk  in  NUM_SP*MAX_SV  element mask; bits [s*NUM_SP +: NUM_SP] belong to sub-vector s
out_vld  out  1  sub-vector valid to SPA
out_stall  in  1  SPA stall
out_tid  out  TID_W  thread id
out_op  out  OP_W  opcode
out_sv  out  SV_W  sub-vector index (SPA subVec)
out_emsk  out  NUM_SP  lane mask of this sub-vector
out_first  out  1  first issued sub-vector of the instruction
out_last  out  1  last issued sub-vector of the instruction
exp_vld  in  1  execute exception
exp_tid  in  TID_W  thread raising the exception
done_vld  out  1  instruction retired from the sequencer (1-cycle pulse)
done_tid  out  TID_W  thread of the retired instruction
done_abort  out  1  retired by exception cancel
busy  out  1  state != IDLE

Behaviour:
- Interface: clock clk; reset rst_n, asynchronous, active-low.
- Reset: all outputs 0. State IDLE. Internal instruction registers cleared. A reset asserted mid-instruction discards the instruction silently, with no done pulse.
- Sub-vector s is live if s <= nsv and its mask slice is nonzero.
- Handshake: an instruction is accepted when in_vld && in_rdy at the clock edge.
- in_rdy = (IDLE || (ISSUE && out_vld && out_last && !out_stall)) && !(exp_vld && exp_tid == in_tid). This is combinational and allows back-to-back issue.
- FSM IDLE:
  - On accept with at least one live sub-vector: go to ISSUE. The first live sub-vector appears at the next cycle with out_first=1 (accept-to-issue latency is 1 cycle).
  - On accept with zero live sub-vectors: stay IDLE. Next cycle done_vld=1, done_abort=0, out_vld stays 0.
- FSM ISSUE:
  - out_vld=1. Fields are registered.
  - If out_stall: all out_* hold.
  - Otherwise, the next cycle presents the next live sub-vector at a higher index, found by a priority encoder over the remaining live mask. Dead sub-vectors take no cycles.
  - out_last=1 when no live sub-vector remains above the current one.
  - On the last handshake: done_vld next cycle with abort=0. Then either the newly accepted instruction is loaded (stay ISSUE) or the FSM goes to IDLE.
- Exception: exp_vld && exp_tid == current tid in ISSUE.
  - If !out_stall, the sub-vector currently presented counts as consumed.
  - If it was out_last: normal completion, abort=0.
  - Otherwise: out_vld=0 next cycle, done_vld with done_abort=1, state IDLE, remaining sub-vectors dropped.
  - If out_stall: the presented sub-vector is dropped too, with done_abort=1.
  - A non-matching exp_tid is ignored.
- At most one done_vld per cycle. Exception with equal in_tid blocks acceptance, so an abort can never coincide with a new zero-live instruction.
- out_sv is the original index, not the issued count. nsv=0 is a 1-sub-vector instruction.

Decomposition:
- ip4_rtl_pkg: typedef svseq_in_s {tid, op, nsv, emsk}, svseq_out_s {tid, op, sv, emsk, first, last}, enum svseq_state_e {SVS_IDLE, SVS_ISSUE}. Constants NUM_SP, MAX_SV.
- One sub-module: ip4_rtl_sv_penc. Priority encoder: remaining live mask -> next index, none flag.

Test Plan:
1. nsv=3, emsk all ones, no stall -> out_sv 0,1,2,3 on cycles 1–4, first at sv0, last at sv3, done cycle 5 abort=0.
2. nsv=3, emsk slice1=slice2=0 -> issues sv0 then sv3 on consecutive cycles, last at sv3.
3. nsv=1, emsk=0 -> no out_vld, done_vld cycle 1 abort=0, tid matches.
4. Stall for 3 cycles during sv1 of a 4-sv instruction -> sv1 and its fields hold 4 cycles, total 7 issue cycles, done after sv3.
5. Exception tid=2 during sv1 of tid=2 (no stall) -> sv2/sv3 never issued, done abort=1. Same exception with tid=5 -> ignored.
6. Back-to-back: second instruction valid during the last sv of the first -> in_rdy=1, its sv0 follows with no bubble, done for the first coincides with its sv0.

Source files
------------

// File: rtl/ip4_rtl_pkg.sv
// Shared types and constants for the SPA sub-vector issue sequencer.
package ip4_rtl_pkg;

    localparam int NUM_SP = 8;
    localparam int MAX_SV = 4;
    localparam int TID_W  = 3;
    localparam int OP_W   = 8;
    localparam int SV_W   = $clog2(MAX_SV);

    typedef struct packed {
        logic [TID_W-1:0]         tid;
        logic [OP_W-1:0]          op;
        logic [SV_W-1:0]          nsv;
        logic [NUM_SP*MAX_SV-1:0] emsk;
    } svseq_in_s;

    typedef struct packed {
        logic [TID_W-1:0]  tid;
        logic [OP_W-1:0]   op;
        logic [SV_W-1:0]   sv;
        logic [NUM_SP-1:0] emsk;
        logic              first;
        logic              last;
    } svseq_out_s;

    typedef enum logic [0:0] {
        SVS_IDLE  = 1'b0,
        SVS_ISSUE = 1'b1
    } svseq_state_e;

    // A sub-vector is live when it lies within nsv and has at least one lane enabled.
    function automatic logic [MAX_SV-1:0] live_mask(input logic [SV_W-1:0] nsv,
                                                    input logic [NUM_SP*MAX_SV-1:0] emsk);
        logic [MAX_SV-1:0] m;
        for (int s = 0; s < MAX_SV; s++) begin
            m[s] = (SV_W'(s) <= nsv) && (|emsk[s*NUM_SP +: NUM_SP]);
        end
        return m;
    endfunction

endpackage

// File: rtl/ip4_rtl_sv_penc.sv
// Lowest-index-first priority encoder over a live sub-vector mask.
module ip4_rtl_sv_penc
    import ip4_rtl_pkg::*;
(
    input  logic [MAX_SV-1:0] mask,
    output logic [SV_W-1:0]   idx,
    output logic              none
);

    // Scan from the top so the lowest set bit is the one that sticks
    always_comb begin
        idx  = '0;
        none = ~|mask;
        for (int s = MAX_SV - 1; s >= 0; s--) begin
            idx = mask[s] ? SV_W'(s) : idx;
        end
    end

endmodule

// File: rtl/ip4_rtl_spa_svseq.sv
// Sub-vector issue sequencer: splits one vector instruction into live
// NUM_SP-wide sub-vectors, honours SPA stall and thread exception cancel.
module ip4_rtl_spa_svseq
    import ip4_rtl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [TID_W-1:0]         in_tid,
    input  logic [OP_W-1:0]          in_op,
    input  logic [SV_W-1:0]          in_nsv,
    input  logic [NUM_SP*MAX_SV-1:0] in_emsk,
    output logic                     out_vld,
    input  logic                     out_stall,
    output logic [TID_W-1:0]         out_tid,
    output logic [OP_W-1:0]          out_op,
    output logic [SV_W-1:0]          out_sv,
    output logic [NUM_SP-1:0]        out_emsk,
    output logic                     out_first,
    output logic                     out_last,
    input  logic                     exp_vld,
    input  logic [TID_W-1:0]         exp_tid,
    output logic                     done_vld,
    output logic [TID_W-1:0]         done_tid,
    output logic                     done_abort,
    output logic                     busy
);

    svseq_state_e             state_r, state_s;
    svseq_out_s               cur_r, cur_s;
    logic [MAX_SV-1:0]        rem_r, rem_s;
    logic [NUM_SP*MAX_SV-1:0] emsk_r, emsk_s;
    logic                     done_vld_r, done_vld_s, done_abort_r, done_abort_s;
    logic [TID_W-1:0]         done_tid_r, done_tid_s;
    logic                     pend_vld_r, pend_vld_s, pend_abort_r, pend_abort_s;
    logic [TID_W-1:0]         pend_tid_r, pend_tid_s;
    logic [MAX_SV-1:0]        live_in_s, rest_in_s, rest_rem_s;
    logic [SV_W-1:0]          in_idx_s, rem_idx_s;
    logic                     in_none_s, rem_none_s;
    logic                     issue_s, exc_s, acc_s, rdy_s;
    logic                     comp_vld_s, comp_abort_s, zero_vld_s;

    localparam logic [MAX_SV-1:0] ONE_MASK = {{(MAX_SV-1){1'b0}}, 1'b1};

    assign live_in_s  = live_mask(in_nsv, in_emsk);
    assign rest_in_s  = live_in_s & (live_in_s - ONE_MASK);
    assign rest_rem_s = rem_r & (rem_r - ONE_MASK);

    ip4_rtl_sv_penc u_penc_in  (.mask(live_in_s), .idx(in_idx_s),  .none(in_none_s));
    ip4_rtl_sv_penc u_penc_rem (.mask(rem_r),     .idx(rem_idx_s), .none(rem_none_s));

    assign issue_s = (state_r == SVS_ISSUE);
    assign exc_s   = issue_s && exp_vld && (exp_tid == cur_r.tid);
    // Ready is held low in reset so every output reads 0 while rst_n is asserted.
    assign rdy_s   = rst_n && ((state_r == SVS_IDLE) || (issue_s && cur_r.last && !out_stall))
                     && !(exp_vld && (exp_tid == in_tid));
    assign acc_s   = in_vld && rdy_s;

    // Next state, next sub-vector selection and retirement events
    always_comb begin
        state_s      = state_r;
        cur_s        = cur_r;
        rem_s        = rem_r;
        emsk_s       = emsk_r;
        comp_vld_s   = 1'b0;
        comp_abort_s = 1'b0;
        zero_vld_s   = 1'b0;
        case (state_r)
            SVS_ISSUE: begin
                if (!out_stall) begin
                    if (cur_r.last || rem_none_s) begin
                        comp_vld_s = 1'b1;
                        state_s    = SVS_IDLE;
                        cur_s      = '0;
                        rem_s      = '0;
                        emsk_s     = '0;
                    end else if (exc_s) begin
                        comp_vld_s   = 1'b1;
                        comp_abort_s = 1'b1;
                        state_s      = SVS_IDLE;
                        cur_s        = '0;
                        rem_s        = '0;
                        emsk_s       = '0;
                    end else begin
                        cur_s.sv    = rem_idx_s;
                        cur_s.emsk  = emsk_r[rem_idx_s*NUM_SP +: NUM_SP];
                        cur_s.first = 1'b0;
                        cur_s.last  = (rest_rem_s == '0);
                        rem_s       = rest_rem_s;
                    end
                end else if (exc_s) begin
                    // Stalled sub-vector was never consumed, so it is dropped with the rest
                    comp_vld_s   = 1'b1;
                    comp_abort_s = 1'b1;
                    state_s      = SVS_IDLE;
                    cur_s        = '0;
                    rem_s        = '0;
                    emsk_s       = '0;
                end else begin
                    cur_s = cur_r;
                end
            end
            SVS_IDLE: begin
                state_s = SVS_IDLE;
            end
            default: begin
                state_s = SVS_IDLE;
                cur_s   = '0;
                rem_s   = '0;
                emsk_s  = '0;
            end
        endcase
        if (acc_s) begin
            if (in_none_s) begin
                zero_vld_s = 1'b1;
            end else begin
                state_s     = SVS_ISSUE;
                cur_s.tid   = in_tid;
                cur_s.op    = in_op;
                cur_s.sv    = in_idx_s;
                cur_s.emsk  = in_emsk[in_idx_s*NUM_SP +: NUM_SP];
                cur_s.first = 1'b1;
                cur_s.last  = (rest_in_s == '0);
                rem_s       = rest_in_s;
                emsk_s      = in_emsk;
            end
        end else begin
            zero_vld_s = 1'b0;
        end
    end

    // Serialise retirements: a completion plus a zero-live accept in one cycle
    // retire on consecutive cycles through a one-deep pending slot.
    always_comb begin
        done_vld_s   = 1'b0;
        done_abort_s = 1'b0;
        done_tid_s   = '0;
        pend_vld_s   = 1'b0;
        pend_abort_s = 1'b0;
        pend_tid_s   = '0;
        if (pend_vld_r) begin
            done_vld_s   = 1'b1;
            done_abort_s = pend_abort_r;
            done_tid_s   = pend_tid_r;
            if (comp_vld_s) begin
                pend_vld_s   = 1'b1;
                pend_abort_s = comp_abort_s;
                pend_tid_s   = cur_r.tid;
            end else if (zero_vld_s) begin
                pend_vld_s = 1'b1;
                pend_tid_s = in_tid;
            end else begin
                pend_vld_s = 1'b0;
            end
        end else if (comp_vld_s) begin
            done_vld_s   = 1'b1;
            done_abort_s = comp_abort_s;
            done_tid_s   = cur_r.tid;
            if (zero_vld_s) begin
                pend_vld_s = 1'b1;
                pend_tid_s = in_tid;
            end else begin
                pend_vld_s = 1'b0;
            end
        end else if (zero_vld_s) begin
            done_vld_s = 1'b1;
            done_tid_s = in_tid;
        end else begin
            done_vld_s = 1'b0;
        end
    end

    // State and output registers; reset discards any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= SVS_IDLE;
            cur_r        <= '0;
            rem_r        <= '0;
            emsk_r       <= '0;
            done_vld_r   <= 1'b0;
            done_abort_r <= 1'b0;
            done_tid_r   <= '0;
            pend_vld_r   <= 1'b0;
            pend_abort_r <= 1'b0;
            pend_tid_r   <= '0;
        end else begin
            state_r      <= state_s;
            cur_r        <= cur_s;
            rem_r        <= rem_s;
            emsk_r       <= emsk_s;
            done_vld_r   <= done_vld_s;
            done_abort_r <= done_abort_s;
            done_tid_r   <= done_tid_s;
            pend_vld_r   <= pend_vld_s;
            pend_abort_r <= pend_abort_s;
            pend_tid_r   <= pend_tid_s;
        end
    end

    assign in_rdy     = rdy_s;
    assign out_vld    = issue_s;
    assign busy       = issue_s;
    assign out_tid    = cur_r.tid;
    assign out_op     = cur_r.op;
    assign out_sv     = cur_r.sv;
    assign out_emsk   = cur_r.emsk;
    assign out_first  = cur_r.first;
    assign out_last   = cur_r.last;
    assign done_vld   = done_vld_r;
    assign done_tid   = done_tid_r;
    assign done_abort = done_abort_r;

endmodule

// File: tb/tb_ip4_rtl_spa_svseq.sv
// Bench for the sub-vector issue sequencer: directed vector table, hand
// sequences for stall/exception/back-to-back, and randomized traffic
// checked cycle by cycle against a queue-based reference model.
module tb_ip4_rtl_spa_svseq;
    import ip4_rtl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vld = 1'b0, in_rdy;
    logic [2:0]  in_tid = '0;
    logic [7:0]  in_op = '0;
    logic [1:0]  in_nsv = '0;
    logic [31:0] in_emsk = '0;
    logic        out_vld, out_stall = 1'b0;
    logic [2:0]  out_tid;
    logic [7:0]  out_op;
    logic [1:0]  out_sv;
    logic [7:0]  out_emsk;
    logic        out_first, out_last;
    logic        exp_vld = 1'b0;
    logic [2:0]  exp_tid = '0;
    logic        done_vld, done_abort, busy;
    logic [2:0]  done_tid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ip4_rtl_spa_svseq dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_tid(in_tid), .in_op(in_op),
        .in_nsv(in_nsv), .in_emsk(in_emsk),
        .out_vld(out_vld), .out_stall(out_stall), .out_tid(out_tid), .out_op(out_op),
        .out_sv(out_sv), .out_emsk(out_emsk), .out_first(out_first), .out_last(out_last),
        .exp_vld(exp_vld), .exp_tid(exp_tid),
        .done_vld(done_vld), .done_tid(done_tid), .done_abort(done_abort), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [2:0] tid; logic abort; } done_t;
    bit          chk_en = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_first;
    logic [2:0]  m_tid;
    logic [7:0]  m_op;
    logic [31:0] m_emsk;
    int          m_q[$];
    done_t       m_dq[$];

    always @(negedge clk) begin
        logic       s_vld, s_stall, s_exp, rdy_e, acc, exc, dv;
        logic [2:0] s_tid, s_etid;
        logic [7:0] s_op;
        logic [1:0] s_nsv;
        logic [31:0] s_emsk;
        done_t      d;
        int         q[$];
        #4;
        if (chk_en) begin
            s_vld = in_vld; s_tid = in_tid; s_op = in_op; s_nsv = in_nsv; s_emsk = in_emsk;
            s_stall = out_stall; s_exp = exp_vld; s_etid = exp_tid;
            rdy_e = (!m_busy || (m_q.size() == 1 && !s_stall)) && !(s_exp && s_etid == s_tid);
            chk("in_rdy", 32'(in_rdy), 32'(rdy_e));
            acc = s_vld && rdy_e;
            @(posedge clk);
            if (m_busy) begin
                exc = s_exp && (s_etid == m_tid);
                if (!s_stall) begin
                    if (m_q.size() == 1) begin
                        m_dq.push_back('{tid: m_tid, abort: 1'b0}); m_busy = 1'b0;
                    end else if (exc) begin
                        m_dq.push_back('{tid: m_tid, abort: 1'b1}); m_busy = 1'b0;
                    end else begin
                        void'(m_q.pop_front()); m_first = 1'b0;
                    end
                end else if (exc) begin
                    m_dq.push_back('{tid: m_tid, abort: 1'b1}); m_busy = 1'b0;
                end
                if (!m_busy) m_q.delete();
            end
            if (acc) begin
                q.delete();
                for (int s = 0; s <= int'(s_nsv); s++)
                    if (s_emsk[s*8 +: 8] != 8'h00) q.push_back(s);
                if (q.size() == 0) begin
                    m_dq.push_back('{tid: s_tid, abort: 1'b0});
                end else begin
                    m_q = q; m_busy = 1'b1; m_first = 1'b1;
                    m_tid = s_tid; m_op = s_op; m_emsk = s_emsk;
                end
            end
            dv = (m_dq.size() > 0);
            d  = dv ? m_dq.pop_front() : '0;
            #1;
            chk("out_vld", 32'(out_vld), 32'(m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            if (m_busy) begin
                chk("out_sv", 32'(out_sv), 32'(m_q[0]));
                chk("out_tid", 32'(out_tid), 32'(m_tid));
                chk("out_op", 32'(out_op), 32'(m_op));
                chk("out_emsk", 32'(out_emsk), 32'(m_emsk[m_q[0]*8 +: 8]));
                chk("out_first", 32'(out_first), 32'(m_first));
                chk("out_last", 32'(out_last), 32'(m_q.size() == 1));
            end
            chk("done_vld", 32'(done_vld), 32'(dv));
            if (dv) begin
                chk("done_tid", 32'(done_tid), 32'(d.tid));
                chk("done_abort", 32'(done_abort), 32'(d.abort));
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic send(input logic [2:0] t, input logic [7:0] o, input logic [1:0] n,
                        input logic [31:0] e);
        in_vld = 1'b1; in_tid = t; in_op = o; in_nsv = n; in_emsk = e;
        @(posedge clk); #1;
        in_vld = 1'b0;
    endtask

    task automatic run_dir(input logic [2:0] t, input logic [1:0] n, input logic [31:0] e,
                           input int st_lo, input int st_hi, input int ex_c,
                           input logic [2:0] ex_t,
                           output int nvld, output int nsv1, output int dat, output logic ab);
        nvld = 0; nsv1 = 0; dat = -1; ab = 1'b0;
        send(t, 8'h5A, n, e);
        for (int c = 1; c <= 12; c++) begin
            if (out_vld) begin
                nvld++;
                if (out_sv == 2'd1) nsv1++;
            end
            if (done_vld && dat < 0) begin dat = c; ab = done_abort; end
            out_stall = (c >= st_lo && c <= st_hi);
            exp_vld   = (c == ex_c);
            exp_tid   = ex_t;
            @(posedge clk); #1;
        end
        out_stall = 1'b0; exp_vld = 1'b0;
    endtask

    typedef struct { logic [1:0] nsv; logic [31:0] emsk; int n; logic [7:0] seq; } vec_t;
    vec_t vt[6];

    initial begin
        int nvld, nsv1, dat, got_n, done_at;
        logic ab, dab;
        logic [2:0] dt;
        logic [7:0] got_seq;
        logic [31:0] e;

        vt[0] = '{2'd3, 32'hFFFF_FFFF, 4, 8'hE4};
        vt[1] = '{2'd3, 32'hFF00_00FF, 2, 8'h0C};
        vt[2] = '{2'd1, 32'h0000_0000, 0, 8'h00};
        vt[3] = '{2'd0, 32'hFFFF_FF01, 1, 8'h00};
        vt[4] = '{2'd2, 32'hFF80_0000, 1, 8'h02};
        vt[5] = '{2'd3, 32'h0100_0000, 1, 8'h03};

        repeat (3) @(posedge clk);
        #1;
        chk("rst out_vld", 32'(out_vld), 32'd0);
        chk("rst done_vld", 32'(done_vld), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst in_rdy", 32'(in_rdy), 32'd0);
        chk("rst out_first", 32'(out_first), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Vector table: single instructions, no stall, no exception
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            send(3'(i), 8'hA0 + 8'(i), vt[i].nsv, vt[i].emsk);
            got_n = 0; got_seq = '0; done_at = -1; dab = 1'b1; dt = '0;
            for (int c = 1; c <= 6; c++) begin
                if (out_vld) begin
                    chk("tbl first", 32'(out_first), 32'(got_n == 0));
                    chk("tbl last", 32'(out_last), 32'(got_n == vt[i].n - 1));
                    if (got_n < 4) got_seq[got_n*2 +: 2] = out_sv;
                    got_n++;
                end
                if (done_vld && done_at < 0) begin done_at = c; dab = done_abort; dt = done_tid; end
                @(posedge clk); #1;
            end
            chk("tbl count", 32'(got_n), 32'(vt[i].n));
            chk("tbl seq", 32'(got_seq), 32'(vt[i].seq));
            chk("tbl done cycle", 32'(done_at), 32'(vt[i].n + 1));
            chk("tbl done abort", 32'(dab), 32'd0);
            chk("tbl done tid", 32'(dt), 32'(i));
        end

        // Stall for 3 cycles while sv1 is presented
        run_dir(3'd1, 2'd3, 32'hFFFF_FFFF, 2, 4, 0, 3'd0, nvld, nsv1, dat, ab);
        chk("stall vld cycles", 32'(nvld), 32'd7);
        chk("stall sv1 cycles", 32'(nsv1), 32'd4);
        chk("stall done cycle", 32'(dat), 32'd8);
        chk("stall abort", 32'(ab), 32'd0);

        // Matching exception during sv1, no stall
        run_dir(3'd2, 2'd3, 32'hFFFF_FFFF, 0, 0, 2, 3'd2, nvld, nsv1, dat, ab);
        chk("exc vld cycles", 32'(nvld), 32'd2);
        chk("exc done cycle", 32'(dat), 32'd3);
        chk("exc abort", 32'(ab), 32'd1);

        // Non-matching exception is ignored
        run_dir(3'd2, 2'd3, 32'hFFFF_FFFF, 0, 0, 2, 3'd5, nvld, nsv1, dat, ab);
        chk("exc5 vld cycles", 32'(nvld), 32'd4);
        chk("exc5 done cycle", 32'(dat), 32'd5);
        chk("exc5 abort", 32'(ab), 32'd0);

        // Matching exception while sv1 is stalled drops it too
        run_dir(3'd3, 2'd3, 32'hFFFF_FFFF, 2, 2, 2, 3'd3, nvld, nsv1, dat, ab);
        chk("excst vld cycles", 32'(nvld), 32'd2);
        chk("excst done cycle", 32'(dat), 32'd3);
        chk("excst abort", 32'(ab), 32'd1);

        // Back-to-back: second instruction offered during the first one's last sv
        @(negedge clk);
        send(3'd1, 8'h11, 2'd1, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        in_vld = 1'b1; in_tid = 3'd4; in_op = 8'h44; in_nsv = 2'd1; in_emsk = 32'hFFFF_FFFF;
        #1;
        chk("b2b last", 32'(out_last), 32'd1);
        chk("b2b in_rdy", 32'(in_rdy), 32'd1);
        @(posedge clk); #1;
        in_vld = 1'b0;
        chk("b2b out_vld", 32'(out_vld), 32'd1);
        chk("b2b out_tid", 32'(out_tid), 32'd4);
        chk("b2b out_sv", 32'(out_sv), 32'd0);
        chk("b2b out_first", 32'(out_first), 32'd1);
        chk("b2b done_vld", 32'(done_vld), 32'd1);
        chk("b2b done_tid", 32'(done_tid), 32'd1);
        repeat (4) @(posedge clk);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            for (int s = 0; s < 4; s++)
                e[s*8 +: 8] = ($urandom_range(0, 9) < 4) ? 8'h00 : 8'($urandom);
            in_vld    = ($urandom_range(0, 1) == 0);
            in_tid    = 3'($urandom_range(0, 3));
            in_op     = 8'($urandom);
            in_nsv    = 2'($urandom);
            in_emsk   = e;
            out_stall = ($urandom_range(0, 3) == 0);
            exp_vld   = ($urandom_range(0, 9) == 0);
            exp_tid   = 3'($urandom_range(0, 3));
        end
        @(negedge clk);
        in_vld = 1'b0; out_stall = 1'b0; exp_vld = 1'b0;
        repeat (10) @(posedge clk);

        // Reset mid-instruction: silent discard, no done pulse
        @(negedge clk);
        send(3'd6, 8'h66, 2'd3, 32'hFFFF_FFFF);
        chk_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid rst out_vld", 32'(out_vld), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("post rst done_vld", 32'(done_vld), 32'd0);
            chk("post rst out_vld", 32'(out_vld), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
